// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and helpers for the UART receive deserializer
// Purpose: receiver state encoding and the baud divider calculation.
// Ports: none (package).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  // Clocks per oversample tick, integer-truncated.
  function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
    return clk_freq / (baud_rate * oversample);
  endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample tick generator for the UART receiver
// Purpose: one-clk tick every DIV clocks, counter held at 0 while restart is high.
// Ports:
//   clk     in  system clock
//   rstn    in  asynchronous active-low reset
//   restart in  clears the divider (first tick DIV clocks after release)
//   tick    out one-cycle oversample tick
module baud_tick_gen #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rstn,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (restart || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = !restart && (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// rtl/uart_rx_deser.sv - oversampling UART receiver with valid/ready byte output
// Purpose: synchronizes the RX pin, validates start/data/stop (and optional
//   even parity when UART_RX_PARITY_EN is defined), presents bytes on valid/ready,
//   and pulses frame_err / overrun / parity_err instead of delivering bad bytes.
// Ports:
//   clk        in  system clock
//   rstn       in  asynchronous active-low reset
//   sig        in  raw serial input, idle high, asynchronous
//   data       out received byte, stable while valid
//   valid      out byte available
//   ready      in  consumer accepts when valid && ready
//   frame_err  out one-cycle pulse, stop bit sampled 0
//   overrun    out one-cycle pulse, good byte dropped because valid was pending
//   parity_err out one-cycle pulse on parity mismatch (0 without UART_RX_PARITY_EN)
module uart_rx_deser #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  sig,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  parity_err
);
  import uart_rx_pkg::*;

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int IW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_WIDTH - 1);

  logic                  r_sync1, r_sync2, r_prev;
  logic                  w_rx_s;
  state_t                r_state, w_state_nxt;
  logic [TW-1:0]         r_tick_cnt, w_tick_cnt_nxt;
  logic [IW-1:0]         r_bit_idx, w_bit_idx_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  w_tick, w_restart;
  logic                  w_stop_sample, w_frame_err, w_parity_err;
  logic                  w_deliver, w_accept, w_load, w_overrun;
`ifdef UART_RX_PARITY_EN
  logic                  r_par, w_par_nxt;
`endif

  assign w_rx_s = r_sync2;

  // Divider is held cleared in IDLE so the first tick lands DIV clocks after the start edge.
  assign w_restart = (r_state == IDLE);

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .rstn    (rstn),
    .restart (w_restart),
    .tick    (w_tick)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_sync1    <= 1'b1;
      r_sync2    <= 1'b1;
      r_prev     <= 1'b1;
      r_tick_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_sync1    <= sig;
      r_sync2    <= r_sync1;
      r_prev     <= r_sync2;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tick_cnt_nxt = r_tick_cnt;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_stop_sample  = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_nxt      = r_par;
`endif
    case (r_state)
      IDLE: begin
        w_tick_cnt_nxt = '0;
        // Edge, not level: a line stuck low cannot re-trigger.
        if (r_prev && !w_rx_s) w_state_nxt = START;
      end
      START: begin
        if (w_tick) begin
          if (r_tick_cnt == MID_TICK) begin
            w_tick_cnt_nxt = '0;
            w_bit_idx_nxt  = '0;
            w_state_nxt    = w_rx_s ? IDLE : DATA;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (w_tick) begin
          if (r_tick_cnt == FULL_TICK) begin
            w_tick_cnt_nxt         = '0;
            w_shift_nxt[r_bit_idx] = w_rx_s;
            if (r_bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              w_state_nxt = PARITY;
`else
              w_state_nxt = STOP;
`endif
            end else begin
              w_bit_idx_nxt = r_bit_idx + IW'(1);
            end
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_tick) begin
          if (r_tick_cnt == FULL_TICK) begin
            w_tick_cnt_nxt = '0;
            w_par_nxt      = w_rx_s;
            w_state_nxt    = STOP;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (w_tick) begin
          if (r_tick_cnt == FULL_TICK) begin
            w_tick_cnt_nxt = '0;
            w_stop_sample  = 1'b1;
            w_state_nxt    = IDLE;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_frame_err  = w_stop_sample && !w_rx_s;
`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign w_parity_err = w_stop_sample && ((^r_shift) ^ r_par);
`else
  assign w_parity_err = 1'b0;
`endif
  assign w_deliver = w_stop_sample && w_rx_s && !w_parity_err;
  assign w_accept  = valid && ready;
  // A same-cycle acceptance frees the slot, so the new byte is taken without overrun.
  assign w_load    = w_deliver && (!valid || w_accept);
  assign w_overrun = w_deliver && valid && !ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= w_frame_err;
      overrun   <= w_overrun;
      if (w_load) begin
        data  <= r_shift;
        valid <= 1'b1;
      end else if (w_accept) begin
        valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_par      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      r_par      <= w_par_nxt;
      parity_err <= w_parity_err;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx_deser.md
Name: uart_rx_deser

Overview:
- Serial UART receiver front end. Oversamples the asynchronous RX pin, validates start, data and stop bits, and presents each byte on a valid/ready handshake.
- Sits directly upstream of the loopback top's rx handshake. Its data/valid/ready drive the RAM write path (write on valid && ready).
- Framing errors and overruns are flagged, never written.

Parameters:
- DATA_WIDTH, 8, data bits per frame, LSB first.
- BAUD_RATE, 115200, line rate in bit/s.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- OVERSAMPLE, 16, ticks per bit; must be even and >= 8.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset; asynchronous, active-low.
- sig  in  1  raw serial input; idle high; asynchronous to clk.
- data  out  DATA_WIDTH  received byte; stable while valid=1.
- valid  out  1  byte available.
- ready  in  1  consumer accepts data when valid && ready.
- frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- overrun  out  1  one-cycle pulse: new byte dropped because valid was still pending.
- parity_err  out  1  one-cycle pulse on parity mismatch; constant 0 without PARITY_EN.

Behaviour:
- Reset values (asynchronous on rstn=0): data=0, valid=0, all error pulses 0, state IDLE, counters 0, synchronizer flops=1.
- Synchronizer: 2-flop synchronizer on sig; all logic uses the synchronized value (rx_s).
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer-truncated (54 at defaults).
  - Produces a one-clk tick every DIV clocks.
  - Restarts from 0 when leaving IDLE.
- IDLE:
  - Wait for falling edge of rx_s (previous 1, current 0), then go to START with tick count cleared.
  - A line held low never re-triggers without first returning high.
- START: at tick OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - 1 -> false start, back to IDLE, no flags.
  - 0 -> DATA, bit index 0, tick count 0.
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into shift register bit[index], LSB first.
  - After bit DATA_WIDTH-1 go to PARITY (when enabled) or STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - 0 -> frame_err pulse, byte discarded, go to IDLE.
  - 1 -> deliver, go to IDLE. Deliver means:
    - If valid=0, or valid && ready in this same cycle: load data, valid=1 on the next clk.
    - Else: overrun pulse, old data kept, new byte dropped.
- Handshake:
  - valid stays high until the clk after valid && ready; data does not change while valid=1.
  - If acceptance and a new delivery coincide, valid stays 1 with the new data; no overrun.
- Latency: valid rises 1 clk after the mid-stop-bit sample; nominally ~9.5 bit times plus 3 clk after the start edge.
- ready is ignored except for the handshake; reception never stalls.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP samples one even-parity bit.
  - Mismatch -> parity_err pulse at the stop-bit sample; the byte is discarded even if the stop bit is good.
  - If the stop bit is also 0, both frame_err and parity_err pulse.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Package uart_rx_pkg:
  - state enum {IDLE, START, DATA, PARITY, STOP};
  - function computing DIV from CLK_FREQ/BAUD_RATE/OVERSAMPLE.
- Sub-module baud_tick_gen: parameter DIV; inputs clk, rstn, restart; output tick.

Test Plan:
1. ready=1; send 0xA5 at 115200 (868 clk/bit) -> one valid cycle with data=0xA5; no error flags.
2. ready=0; send 0x3C then 0x81; raise ready afterwards -> overrun pulses once at the 0x81 stop sample; data stays 0x3C and is accepted when ready rises; valid then drops.
3. sig low for 200 clk then high -> false start: no valid, no flags, back in IDLE; a following 0x5A is received correctly.
4. Send 0x55 with stop bit 0, then hold the line low for 2 frames -> exactly one frame_err pulse, no valid; after the line returns high, 0x12 is received correctly.
5. Assert rstn=0 mid-bit-4 of 0xFF while a prior byte is pending -> valid=0 and data=0 immediately. Release and send 0x0F -> data=0x0F, valid.
6. With UART_RX_PARITY_EN: 0x07 with parity 1 -> valid, data=0x07. 0x07 with parity 0 -> parity_err pulse, no valid.
